// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: default sizes, opcodes, FSM states.
package alu_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_OPW   = 6;
    localparam int unsigned DEF_REGW  = 5;

    localparam logic [5:0] OP_MOVI = 6'h00;
    localparam logic [5:0] OP_MOV  = 6'h01;
    localparam logic [5:0] OP_ADD  = 6'h04;
    localparam logic [5:0] OP_SUB  = 6'h05;
    localparam logic [5:0] OP_NEG  = 6'h06;
    localparam logic [5:0] OP_MUL  = 6'h07;
    localparam logic [5:0] OP_DIV  = 6'h08;
    localparam logic [5:0] OP_OR   = 6'h09;
    localparam logic [5:0] OP_XOR  = 6'h0A;
    localparam logic [5:0] OP_NAND = 6'h0B;
    localparam logic [5:0] OP_NOR  = 6'h0C;
    localparam logic [5:0] OP_XNOR = 6'h0D;
    localparam logic [5:0] OP_NOT  = 6'h0E;
    localparam logic [5:0] OP_LSL  = 6'h0F;
    localparam logic [5:0] OP_LSR  = 6'h10;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation/result handshake bundle between decode, the execute stage and write-back.
interface alu_exec_unit_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OPW   = DEF_OPW,
    parameter int unsigned REGW  = DEF_REGW
) ();

    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_imm;
    logic [REGW-1:0]  in_rdst1;
    logic [REGW-1:0]  in_rdst2;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_lo;
    logic [WIDTH-1:0] out_hi;
    logic [REGW-1:0]  out_rdst1;
    logic [REGW-1:0]  out_rdst2;
    logic             out_wr_lo;
    logic             out_wr_hi;
    logic             out_dz;
    logic             out_illegal;

    // Upstream/downstream environment side.
    modport master (
        output in_valid, in_op, in_a, in_b, in_imm, in_rdst1, in_rdst2, out_ready,
        input  in_ready, out_valid, out_lo, out_hi, out_rdst1, out_rdst2,
        input  out_wr_lo, out_wr_hi, out_dz, out_illegal
    );

    // Execute unit side.
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_imm, in_rdst1, in_rdst2, out_ready,
        output in_ready, out_valid, out_lo, out_hi, out_rdst1, out_rdst2,
        output out_wr_lo, out_wr_hi, out_dz, out_illegal
    );

endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Operand a is the multiplicand/divisor, b the multiplier/dividend. acc and shreg
// form one double-width register: {hi, lo} of the product, or {remainder, quotient}.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hold,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             dz
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             active_q;
    logic             div_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] opnd_q;

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             last;
    logic             step;

    assign last = (count_q == '0);
    // The final iteration waits while the output register is still occupied.
    assign step = active_q && !(last && hold);
    assign done = active_q && last && !hold;
    assign dz   = div_q && (opnd_q == '0);

    // Next value of the double-width register for one multiply or divide step.
    always_comb begin
        sum    = {1'b0, acc_q} + (shreg_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh = {acc_q, shreg_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_q};
        if (div_q) begin
            // Remainder stays below 2^WIDTH, so a clear top bit means the subtract fits.
            if (!diff[WIDTH]) begin
                acc_d   = diff[WIDTH-1:0];
                shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d   = rem_sh[WIDTH-1:0];
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d   = sum[WIDTH:1];
            shreg_d = {sum[0], shreg_q[WIDTH-1:1]};
        end
    end

    assign res_lo = shreg_d;
    assign res_hi = acc_d;

    // Operand load on start, then one iteration per cycle down to count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            shreg_q  <= '0;
            opnd_q   <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            div_q    <= op_div;
            count_q  <= CW'(WIDTH - 1);
            acc_q    <= '0;
            shreg_q  <= opb;
            opnd_q   <= opa;
        end else if (step) begin
            acc_q   <= acc_d;
            shreg_q <= shreg_d;
            if (last) begin
                active_q <= 1'b0;
            end else begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered, handshaked ALU execute stage. Single-cycle ops load the output
// register on accept; MUL/DIV run in alu_seq_muldiv when ALU_EXEC_MULDIV_EN is
// defined, otherwise they are reported as illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OPW   = DEF_OPW,
    parameter int unsigned REGW  = DEF_REGW
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_unit_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_lo_q;
    logic [WIDTH-1:0] out_hi_q;
    logic [REGW-1:0]  out_rdst1_q;
    logic [REGW-1:0]  out_rdst2_q;
    logic             out_wr_lo_q;
    logic             out_wr_hi_q;
    logic             out_dz_q;
    logic             out_illegal_q;
    logic [REGW-1:0]  pend_rdst1_q;
    logic [REGW-1:0]  pend_rdst2_q;

    logic             accept;
    logic             is_muldiv;
    logic             hold;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_ill;
    logic             shift_oob;
    logic [SHW-1:0]   shamt;
    logic             md_done;
    logic             md_dz;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    assign bus.in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign hold         = out_valid_q && !bus.out_ready;

    assign bus.out_valid   = out_valid_q;
    assign bus.out_lo      = out_lo_q;
    assign bus.out_hi      = out_hi_q;
    assign bus.out_rdst1   = out_rdst1_q;
    assign bus.out_rdst2   = out_rdst2_q;
    assign bus.out_wr_lo   = out_wr_lo_q;
    assign bus.out_wr_hi   = out_wr_hi_q;
    assign bus.out_dz      = out_dz_q;
    assign bus.out_illegal = out_illegal_q;

`ifdef ALU_EXEC_MULDIV_EN
    assign is_muldiv = (bus.in_op == OPW'(OP_MUL)) || (bus.in_op == OPW'(OP_DIV));

    alu_seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && is_muldiv),
        .op_div (bus.in_op == OPW'(OP_DIV)),
        .opa    (bus.in_a),
        .opb    (bus.in_b),
        .hold   (hold),
        .done   (md_done),
        .res_lo (md_lo),
        .res_hi (md_hi),
        .dz     (md_dz)
    );
`else
    assign is_muldiv = 1'b0;
    assign md_done   = 1'b0;
    assign md_dz     = 1'b0;
    assign md_lo     = '0;
    assign md_hi     = '0;
`endif

    // Shift amounts of WIDTH or more clear the result.
    assign shift_oob = (bus.in_a >= WIDTH'(WIDTH));
    assign shamt     = bus.in_a[SHW-1:0];

    // Single-cycle result; anything unlisted (MUL/DIV included) is illegal here.
    always_comb begin
        sc_lo  = '0;
        sc_ill = 1'b0;
        case (bus.in_op)
            OPW'(OP_MOVI): sc_lo = bus.in_imm;
            OPW'(OP_MOV):  sc_lo = bus.in_a;
            OPW'(OP_ADD):  sc_lo = bus.in_b + bus.in_a;
            OPW'(OP_SUB):  sc_lo = bus.in_b - bus.in_a;
            OPW'(OP_NEG):  sc_lo = WIDTH'(0) - bus.in_a;
            OPW'(OP_OR):   sc_lo = bus.in_b | bus.in_a;
            OPW'(OP_XOR):  sc_lo = bus.in_b ^ bus.in_a;
            OPW'(OP_NAND): sc_lo = ~(bus.in_b & bus.in_a);
            OPW'(OP_NOR):  sc_lo = ~(bus.in_b | bus.in_a);
            OPW'(OP_XNOR): sc_lo = ~(bus.in_b ^ bus.in_a);
            OPW'(OP_NOT):  sc_lo = ~bus.in_a;
            OPW'(OP_LSL):  sc_lo = shift_oob ? '0 : (bus.in_b << shamt);
            OPW'(OP_LSR):  sc_lo = shift_oob ? '0 : (bus.in_b >> shamt);
            default:       sc_ill = 1'b1;
        endcase
    end

    // Control FSM with registered result; the output register drains on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            out_valid_q   <= 1'b0;
            out_lo_q      <= '0;
            out_hi_q      <= '0;
            out_rdst1_q   <= '0;
            out_rdst2_q   <= '0;
            out_wr_lo_q   <= 1'b0;
            out_wr_hi_q   <= 1'b0;
            out_dz_q      <= 1'b0;
            out_illegal_q <= 1'b0;
            pend_rdst1_q  <= '0;
            pend_rdst2_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && is_muldiv) begin
                        state_q      <= ST_BUSY;
                        pend_rdst1_q <= bus.in_rdst1;
                        pend_rdst2_q <= bus.in_rdst2;
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                        end
                    end else if (accept) begin
                        out_valid_q   <= 1'b1;
                        out_lo_q      <= sc_lo;
                        out_hi_q      <= '0;
                        out_rdst1_q   <= bus.in_rdst1;
                        out_rdst2_q   <= bus.in_rdst2;
                        out_wr_lo_q   <= !sc_ill;
                        out_wr_hi_q   <= 1'b0;
                        out_dz_q      <= 1'b0;
                        out_illegal_q <= sc_ill;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state_q       <= ST_IDLE;
                        out_valid_q   <= 1'b1;
                        out_lo_q      <= md_lo;
                        out_hi_q      <= md_hi;
                        out_rdst1_q   <= pend_rdst1_q;
                        out_rdst2_q   <= pend_rdst2_q;
                        out_wr_lo_q   <= 1'b1;
                        out_wr_hi_q   <= 1'b1;
                        out_dz_q      <= md_dz;
                        out_illegal_q <= 1'b0;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=16) with a behavioural reference model.
module tb_alu_exec_unit;
    import alu_pkg::*;

`ifdef ALU_EXEC_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(16), .OPW(6), .REGW(5)) bus ();

    alu_exec_unit #(.WIDTH(16), .OPW(6), .REGW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        wl;
        logic        wh;
        logic        dz;
        logic        ill;
    } res_t;

    logic [5:0] op_tab [17] = '{6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h02,
                                6'h03};

    // Reference behaviour straight from the opcode table.
    function automatic res_t model(input logic [5:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [15:0] imm);
        res_t r;
        logic [31:0] p;
        r    = '0;
        r.wl = 1'b1;
        case (op)
            6'h00: r.lo = imm;
            6'h01: r.lo = a;
            6'h04: r.lo = b + a;
            6'h05: r.lo = b - a;
            6'h06: r.lo = 16'(0) - a;
            6'h07: begin
                if (MD) begin
                    p    = 32'(a) * 32'(b);
                    r.lo = p[15:0];
                    r.hi = p[31:16];
                    r.wh = 1'b1;
                end else begin
                    r     = '0;
                    r.ill = 1'b1;
                end
            end
            6'h08: begin
                if (MD) begin
                    r.wh = 1'b1;
                    if (a == 16'd0) begin
                        r.lo = 16'hFFFF;
                        r.hi = b;
                        r.dz = 1'b1;
                    end else begin
                        r.lo = b / a;
                        r.hi = b % a;
                    end
                end else begin
                    r     = '0;
                    r.ill = 1'b1;
                end
            end
            6'h09: r.lo = b | a;
            6'h0A: r.lo = b ^ a;
            6'h0B: r.lo = ~(b & a);
            6'h0C: r.lo = ~(b | a);
            6'h0D: r.lo = ~(b ^ a);
            6'h0E: r.lo = ~a;
            6'h0F: r.lo = (a >= 16'd16) ? 16'd0 : (b << a);
            6'h10: r.lo = (a >= 16'd16) ? 16'd0 : (b >> a);
            default: begin
                r     = '0;
                r.ill = 1'b1;
            end
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [5:0] op);
        return (MD && (op == 6'h07 || op == 6'h08)) ? 16 : 0;
    endfunction

    function automatic res_t got_res();
        res_t r;
        r.lo  = bus.out_lo;
        r.hi  = bus.out_hi;
        r.wl  = bus.out_wr_lo;
        r.wh  = bus.out_wr_hi;
        r.dz  = bus.out_dz;
        r.ill = bus.out_illegal;
        return r;
    endfunction

    // Offer one operation and return just after the accepting edge.
    task automatic issue(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                         output bit ok);
        bit rdy;
        @(negedge clk);
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_imm   = imm;
        bus.in_rdst1 = r1;
        bus.in_rdst2 = r2;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid; note any in_ready seen meanwhile.
    task automatic wait_out(output int lat, output bit ok, output bit rdy_seen);
        lat      = 0;
        ok       = 1'b0;
        rdy_seen = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            if (bus.in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_imm    = '0;
        bus.in_rdst1  = '0;
        bus.in_rdst2  = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got_res() !== res_t'(0) || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h valid=%b exp=0", got_res(), bus.out_valid);
        end
        checks++;
        if (bus.out_rdst1 !== 5'd0 || bus.out_rdst2 !== 5'd0) begin
            failures++;
            $display("FAIL reset_tags got=%h/%h exp=0/0", bus.out_rdst1, bus.out_rdst2);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_add();
        bit ok, okv, rs;
        int lat;
        res_t e;
        e = model(6'h04, 16'h0003, 16'hFFFF, 16'h0);
        issue(6'h04, 16'h0003, 16'hFFFF, 16'h0, 5'd5, 5'd9, ok);
        wait_out(lat, okv, rs);
        checks++;
        if (!ok || !okv || lat != 0) begin
            failures++;
            $display("FAIL add_latency got=%0d (acc=%b val=%b) exp=0", lat, ok, okv);
        end
        checks++;
        if (got_res() !== e) begin
            failures++;
            $display("FAIL add_result got=%h exp=%h", got_res(), e);
        end
        checks++;
        if (bus.out_rdst1 !== 5'd5 || bus.out_rdst2 !== 5'd9) begin
            failures++;
            $display("FAIL add_tags got=%0d/%0d exp=5/9", bus.out_rdst1, bus.out_rdst2);
        end
    endtask

    task automatic test_mul();
        bit ok, okv, rs;
        int lat;
        res_t e;
        e = model(6'h07, 16'hFFFF, 16'hFFFF, 16'h0);
        issue(6'h07, 16'hFFFF, 16'hFFFF, 16'h0, 5'd1, 5'd2, ok);
        wait_out(lat, okv, rs);
        checks++;
        if (!ok || !okv || lat != exp_lat(6'h07)) begin
            failures++;
            $display("FAIL mul_latency got=%0d exp=%0d", lat, exp_lat(6'h07));
        end
        checks++;
        if (rs) begin
            failures++;
            $display("FAIL mul_busy_in_ready got=1 exp=0");
        end
        checks++;
        if (got_res() !== e || bus.out_rdst1 !== 5'd1 || bus.out_rdst2 !== 5'd2) begin
            failures++;
            $display("FAIL mul_result got=%h tags=%0d/%0d exp=%h tags=1/2", got_res(),
                     bus.out_rdst1, bus.out_rdst2, e);
        end
    endtask

    task automatic test_div();
        logic [15:0] av [2] = '{16'd7, 16'd0};
        logic [15:0] bv [2] = '{16'd100, 16'h1234};
        bit ok, okv, rs;
        int lat;
        res_t e;
        for (int i = 0; i < 2; i++) begin
            e = model(6'h08, av[i], bv[i], 16'h0);
            issue(6'h08, av[i], bv[i], 16'h0, 5'd3, 5'd4, ok);
            wait_out(lat, okv, rs);
            checks++;
            if (!ok || !okv || lat != exp_lat(6'h08) || got_res() !== e) begin
                failures++;
                $display("FAIL div[%0d] got=%h lat=%0d exp=%h lat=%0d", i, got_res(), lat, e,
                         exp_lat(6'h08));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok, okv, rs;
        int lat;
        res_t e1, e2, e3;
        e1 = model(6'h04, 16'h0011, 16'h0022, 16'h0);
        e2 = model(6'h0A, 16'h00F0, 16'h0FF0, 16'h0);
        e3 = model(6'h0F, 16'd17, 16'h0001, 16'h0);
        // Let any earlier result drain before stalling the output.
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue(6'h04, 16'h0011, 16'h0022, 16'h0, 5'd10, 5'd0, ok);
        wait_out(lat, okv, rs);
        checks++;
        if (!ok || !okv || got_res() !== e1) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=%h", got_res(), e1);
        end
        @(negedge clk);
        bus.in_op    = 6'h0A;
        bus.in_a     = 16'h00F0;
        bus.in_b     = 16'h0FF0;
        bus.in_rdst1 = 5'd11;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_stall_ready[%0d] got=%b exp=0", k, bus.in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || got_res() !== e1 || bus.out_rdst1 !== 5'd10) begin
                failures++;
                $display("FAIL b2b_hold[%0d] got=%h tag=%0d exp=%h tag=10", k, got_res(),
                         bus.out_rdst1, e1);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || got_res() !== e2 || bus.out_rdst1 !== 5'd11) begin
            failures++;
            $display("FAIL b2b_second got=%h tag=%0d exp=%h tag=11", got_res(), bus.out_rdst1,
                     e2);
        end
        @(negedge clk);
        bus.in_op    = 6'h0F;
        bus.in_a     = 16'd17;
        bus.in_b     = 16'h0001;
        bus.in_rdst1 = 5'd12;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || got_res() !== e3 || bus.out_rdst1 !== 5'd12) begin
            failures++;
            $display("FAIL b2b_third got=%h tag=%0d exp=%h tag=12", got_res(), bus.out_rdst1,
                     e3);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [4] = '{6'h02, 6'h03, 6'h3F, 6'h11};
        bit ok, okv, rs;
        int lat;
        res_t e;
        for (int i = 0; i < 4; i++) begin
            e = model(ops[i], 16'hABCD, 16'h1234, 16'h5555);
            issue(ops[i], 16'hABCD, 16'h1234, 16'h5555, 5'd7, 5'd8, ok);
            wait_out(lat, okv, rs);
            checks++;
            if (!ok || !okv || lat != 0 || got_res() !== e) begin
                failures++;
                $display("FAIL illegal[%h] got=%h lat=%0d exp=%h lat=0", ops[i], got_res(), lat, e);
            end
        end
    endtask

    task automatic test_random();
        bit ok, okv, rs;
        int lat;
        int bad;
        res_t e;
        logic [5:0]  op;
        logic [15:0] a, b, imm;
        logic [4:0]  r1, r2;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            op  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 16)];
            a   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            b   = 16'($urandom);
            imm = 16'($urandom);
            r1  = 5'($urandom);
            r2  = 5'($urandom);
            e   = model(op, a, b, imm);
            issue(op, a, b, imm, r1, r2, ok);
            wait_out(lat, okv, rs);
            checks++;
            if (!ok || !okv || lat != exp_lat(op) || got_res() !== e ||
                bus.out_rdst1 !== r1 || bus.out_rdst2 !== r2) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d] op=%h a=%h b=%h got=%h lat=%0d exp=%h lat=%0d",
                             i, op, a, b, got_res(), lat, e, exp_lat(op));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, okv, rs, seen;
        int lat;
        res_t e;
        issue(6'h08, 16'd7, 16'd1000, 16'h0, 5'd6, 5'd6, ok);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (got_res() !== res_t'(0) || bus.out_valid !== 1'b0 || bus.out_rdst1 !== 5'd0 ||
            bus.out_rdst2 !== 5'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h valid=%b exp=0", got_res(), bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midreset_no_result got=valid exp=none");
        end
        e = model(6'h04, 16'h0100, 16'h0023, 16'h0);
        issue(6'h04, 16'h0100, 16'h0023, 16'h0, 5'd2, 5'd3, ok);
        wait_out(lat, okv, rs);
        checks++;
        if (!ok || !okv || lat != 0 || got_res() !== e) begin
            failures++;
            $display("FAIL midreset_add got=%h lat=%0d exp=%h lat=0", got_res(), lat, e);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_back_to_back();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered, handshaked execute stage for the Harvard core: accepts one decoded ALU operation per transaction with pre-read register operands, computes it, and presents the result plus destination tags for write-back. It is parametrised in data width and adds an iterative multiply/divide datapath, backpressure, and status flags. It sits between decode/register-read and register-file write-back.

## Interface
- WIDTH, 16, operand/result width; must be a power of two, at least 8.
- OPW, 6, opcode width.
- REGW, 5, register tag width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  OPW  opcode.
- in_a  in  WIDTH  Rsrc1 value.
- in_b  in  WIDTH  Rsrc2 value.
- in_imm  in  WIDTH  immediate.
- in_rdst1, in_rdst2  in  REGW  destination tags (lo, hi).
- out_valid  out  1  result held.
- out_ready  in  1  write-back consumes the result.
- out_lo, out_hi  out  WIDTH  result low/high words.
- out_rdst1, out_rdst2  out  REGW  tags captured with the operation.
- out_wr_lo, out_wr_hi  out  1  write enables for lo/hi.
- out_dz  out  1  divide by zero.
- out_illegal  out  1  unsupported opcode.

## Operation
- Opcodes: 000000 MOVI lo=imm; 000001 MOV lo=a; 000100 ADD b+a; 000101 SUB b-a; 000110 NEG -a; 000111 MUL {hi,lo}=a*b unsigned; 001000 DIV lo=b/a, hi=b%a unsigned; 001001 OR; 001010 XOR; 001011 NAND; 001100 NOR; 001101 XNOR (all b op a); 001110 NOT ~a; 001111 LSL b<<a; 010000 LSR b>>a logical.
- Add/sub/neg wrap modulo 2^WIDTH. No carry or overflow flags.
- The shift amount is the full unsigned value of a. If a ≥ WIDTH, the result is 0.
- out_wr_lo=1 for every legal opcode. out_wr_hi=1 for MUL and DIV only.
- Any other opcode, including 000010 and 000011, produces a result with out_illegal=1, lo=hi=0, and both write enables 0.
- FSM states:
  - IDLE: in_ready = !out_valid || out_ready.
  - BUSY: in_ready=0. Runs one iteration per cycle.
- On accept of a single-cycle op, the output registers load and the FSM stays in IDLE.
- On accept of MUL or DIV, the operands load and the FSM goes to BUSY with counter=WIDTH-1.
- MUL uses shift-add. DIV uses restoring division.
- When the counter reaches 0, the iteration writes the output registers and the FSM returns to IDLE.
- Divide by zero: the divisor is not special-cased. The result is quotient all ones and remainder = b, with out_dz=1.

## Timing
- Reset: state IDLE, counter 0, and every output register (out_lo, out_hi, out_rdst*, out_wr_*, out_dz, out_illegal, out_valid) is 0.
- in_ready is combinational from the state, out_valid and out_ready.
- A transfer occurs on a rising edge with valid&&ready on that side.
- Single-cycle op latency is 1: out_valid is high after the accepting edge.
- MUL/DIV latency is WIDTH cycles: out_valid is high after the WIDTH-th edge following acceptance.
- Throughput is 1 op/cycle for single-cycle ops while out_ready=1.
- Simultaneous out consume and in accept in IDLE: the new result replaces the old one and out_valid stays 1.
- While out_valid=1 and out_ready=0, all out_* fields hold stable and in_ready=0.
- BUSY ignores in_valid. The output register may still drain during BUSY.
- In BUSY, the final iteration cannot complete while out_valid=1 and out_ready=0; the counter holds at 0 until the output frees.
- Reset asserted mid-operation aborts it immediately: no result is produced and the partial state is discarded.

## Configuration
- ALU_EXEC_MULDIV_EN defined: the iterative multiply/divide sub-module is instantiated and MUL/DIV behave as above.
- ALU_EXEC_MULDIV_EN undefined: no BUSY state. MUL/DIV complete in 1 cycle with out_illegal=1, zero result, and no writes.

## Structure
- alu_pkg holds:
  - opcode localparams (OP_MOVI … OP_LSR);
  - the FSM state typedef (ST_IDLE, ST_BUSY);
  - the default WIDTH/REGW constants.
- Sub-module alu_seq_muldiv holds the shared shift register, accumulator and counter for MUL/DIV. It exposes start/done/hold ports to the top FSM.
- Logic, add/sub and shift functions stay inline in alu_exec_unit.

## Test plan
- Reset then ADD a=0x0003 b=0xFFFF -> one cycle later out_valid=1, lo=0x0002, wr_lo=1, wr_hi=0.
- MUL a=0xFFFF b=0xFFFF -> after 16 cycles hi=0xFFFE, lo=0x0001, both write enables 1, in_ready=0 throughout BUSY.
- DIV b=100 a=7 -> lo=14, hi=2, dz=0. DIV b=0x1234 a=0 -> lo=0xFFFF, hi=0x1234, dz=1.
- Back-to-back ADD/XOR/LSL (LSL b=0x0001 a=17 -> 0) with out_ready low for 3 cycles -> first result held stable, in_ready=0, no loss or reorder after release.
- Opcode 000010 -> out_illegal=1, result 0, no write enables. With ALU_EXEC_MULDIV_EN undefined, MUL -> same response after 1 cycle.
- rst_n pulsed low at iteration 8 of a DIV -> all outputs 0 immediately; next ADD completes normally in 1 cycle.
